// File: rtl/voice_allocator.sv
// Voice allocator: accepts note-on/off events and assigns them to a bank of
// nco/adsr voice pairs. Each event scans the voices one per cycle to find a
// gated voice already playing the key (match) and the lowest idle voice
// (free), then applies the event: retrigger, fresh allocation, round-robin
// steal, or release.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   ev_valid/ev_ready/ev_on/ev_key/ev_freq   note event handshake and payload
//   all_off       panic release of every voice, aborts any event in flight
//   voice_active  adsr active flag per voice (sampled while scanning)
//   gate          adsr gate per voice
//   freq          frequency word per voice, voice i at [i*FREQ_BITS +: FREQ_BITS]
//   stolen        one-cycle pulse when a busy voice was taken over
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned KEY_BITS   = 7,
  parameter int unsigned FREQ_BITS  = 22
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [KEY_BITS-1:0]             ev_key,
  input  logic [FREQ_BITS-1:0]            ev_freq,
  input  logic                            all_off,
  input  logic [NUM_VOICES-1:0]           voice_active,
  output logic [NUM_VOICES-1:0]           gate,
  output logic [NUM_VOICES*FREQ_BITS-1:0] freq,
  output logic                            stolen
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, APPLY, RETRIG} state_t;

  state_t                                  state_q, state_d;
  logic                                    ready_q, ready_d;
  logic [NUM_VOICES-1:0]                   gate_q, gate_d;
  logic [NUM_VOICES-1:0][FREQ_BITS-1:0]    freq_q, freq_d;
  logic [NUM_VOICES-1:0][KEY_BITS-1:0]     key_q, key_d;
  logic [IDX_W-1:0]                        steal_ptr_q, steal_ptr_d;
  logic                                    stolen_q, stolen_d;
  logic                                    ev_on_q, ev_on_d;
  logic [KEY_BITS-1:0]                     ev_key_q, ev_key_d;
  logic [FREQ_BITS-1:0]                    ev_freq_q, ev_freq_d;
  logic [IDX_W-1:0]                        scan_idx_q, scan_idx_d;
  logic                                    match_found_q, match_found_d;
  logic [IDX_W-1:0]                        match_idx_q, match_idx_d;
  logic                                    free_found_q, free_found_d;
  logic [IDX_W-1:0]                        free_idx_q, free_idx_d;
  logic [IDX_W-1:0]                        tgt_q, tgt_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ready_q       <= 1'b1;
      gate_q        <= '0;
      freq_q        <= '0;
      key_q         <= '0;
      steal_ptr_q   <= '0;
      stolen_q      <= 1'b0;
      ev_on_q       <= 1'b0;
      ev_key_q      <= '0;
      ev_freq_q     <= '0;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      tgt_q         <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      gate_q        <= gate_d;
      freq_q        <= freq_d;
      key_q         <= key_d;
      steal_ptr_q   <= steal_ptr_d;
      stolen_q      <= stolen_d;
      ev_on_q       <= ev_on_d;
      ev_key_q      <= ev_key_d;
      ev_freq_q     <= ev_freq_d;
      scan_idx_q    <= scan_idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      tgt_q         <= tgt_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d       = state_q;
    gate_d        = gate_q;
    freq_d        = freq_q;
    key_d         = key_q;
    steal_ptr_d   = steal_ptr_q;
    stolen_d      = 1'b0;
    ev_on_d       = ev_on_q;
    ev_key_d      = ev_key_q;
    ev_freq_d     = ev_freq_q;
    scan_idx_d    = scan_idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    tgt_d         = tgt_q;

    unique case (state_q)
      IDLE: begin
        if (ev_valid) begin
          ev_on_d       = ev_on;
          ev_key_d      = ev_key;
          ev_freq_d     = ev_freq;
          scan_idx_d    = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          state_d       = SCAN;
        end
      end

      SCAN: begin
        // Keep only the first hit of each kind, so lowest index wins
        if (!match_found_q && gate_q[scan_idx_q] && (key_q[scan_idx_q] == ev_key_q)) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_idx_q;
        end
        // A released voice still sounding (active) is not free
        if (!free_found_q && !gate_q[scan_idx_q] && !voice_active[scan_idx_q]) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end
        if (scan_idx_q == LAST_IDX) begin
          state_d = APPLY;
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end

      APPLY: begin
        state_d = IDLE;
        if (ev_on_q) begin
          if (match_found_q) begin
            gate_d[match_idx_q] = 1'b0;
            freq_d[match_idx_q] = ev_freq_q;
            tgt_d               = match_idx_q;
            state_d             = RETRIG;
          end else if (free_found_q) begin
            gate_d[free_idx_q] = 1'b1;
            freq_d[free_idx_q] = ev_freq_q;
            key_d[free_idx_q]  = ev_key_q;
          end else begin
            gate_d[steal_ptr_q] = 1'b0;
            freq_d[steal_ptr_q] = ev_freq_q;
            key_d[steal_ptr_q]  = ev_key_q;
            tgt_d               = steal_ptr_q;
            stolen_d            = 1'b1;
            steal_ptr_d         = (steal_ptr_q == LAST_IDX) ? '0 : steal_ptr_q + IDX_W'(1);
            state_d             = RETRIG;
          end
        end else if (match_found_q) begin
          gate_d[match_idx_q] = 1'b0;
        end
      end

      RETRIG: begin
        gate_d[tgt_q] = 1'b1;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Panic release overrides everything, dropping the event in flight
    if (all_off) begin
      gate_d   = '0;
      stolen_d = 1'b0;
      state_d  = IDLE;
    end
  end

  // ev_ready is registered alongside the state it reflects
  assign ready_d  = (state_d == IDLE);

  assign ev_ready = ready_q;
  assign gate     = gate_q;
  assign freq     = freq_q;
  assign stolen   = stolen_q;

endmodule
